// File: rtl/sram_fifo_if.sv
// Handshake and SRAM-side signal bundle for sram_fifo_ctrl.
// master = the FIFO controller, slave = the producer/consumer/SRAM environment.
interface sram_fifo_if #(
    parameter int ADDR_SZ = 9,
    parameter int DATA_SZ = 64
);
    logic               enq_valid;
    logic               enq_ready;
    logic [DATA_SZ-1:0] enq_data;
    logic               deq_valid;
    logic               deq_ready;
    logic [DATA_SZ-1:0] deq_data;
    logic               sram_write_en;
    logic [ADDR_SZ-1:0] sram_write_addr;
    logic [DATA_SZ-1:0] sram_write_data;
    logic               sram_read_en;
    logic [ADDR_SZ-1:0] sram_read_addr;
    logic [DATA_SZ-1:0] sram_read_data;

    modport master (
        input  enq_valid, enq_data, deq_ready, sram_read_data,
        output enq_ready, deq_valid, deq_data,
               sram_write_en, sram_write_addr, sram_write_data,
               sram_read_en, sram_read_addr
    );

    modport slave (
        output enq_valid, enq_data, deq_ready, sram_read_data,
        input  enq_ready, deq_valid, deq_data,
               sram_write_en, sram_write_addr, sram_write_data,
               sram_read_en, sram_read_addr
    );
endinterface

// File: rtl/sram_fifo_ctrl.sv
// Valid/ready FIFO built on an external 1R1W SRAM with 1-cycle registered read.
// Reads are issued ahead of demand into a 2-entry output buffer that hides the read latency.
module sram_fifo_ctrl #(
    parameter int ADDR_SZ = 9,
    parameter int DATA_SZ = 64,
    parameter int MEM_SZ  = 512
) (
    input  logic         clk,
    input  logic         rst_n,
    sram_fifo_if.master  bus
);
    localparam int PW = ADDR_SZ + 1;

    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      sram_cnt;
    logic               inflight_q, inflight_d;
    logic               alive_q;
    logic [1:0]         ob_cnt_q, ob_cnt_d;
    logic [1:0]         ob_kept;
    logic [DATA_SZ-1:0] obuf_q [2];
    logic [DATA_SZ-1:0] obuf_d [2];
    logic [2:0]         occ;
    logic               enq_fire, deq_fire, issue;

    // Wrap bit keeps full (MEM_SZ) and empty (0) distinct.
    assign sram_cnt  = wr_ptr_q - rd_ptr_q;
    assign enq_fire  = bus.enq_valid & bus.enq_ready;
    assign deq_fire  = bus.deq_valid & bus.deq_ready;
    assign occ       = {1'b0, ob_cnt_q} + {2'b00, inflight_q} - {2'b00, deq_fire};
    // sram_cnt is registered, so a read never hits this cycle's write slot.
    assign issue     = (sram_cnt != '0) & (occ < 3'd2);

    assign bus.enq_ready       = alive_q & (sram_cnt != PW'(MEM_SZ));
    assign bus.deq_valid       = (ob_cnt_q != 2'd0);
    assign bus.deq_data        = obuf_q[0];
    assign bus.sram_write_en   = enq_fire;
    assign bus.sram_write_addr = wr_ptr_q[ADDR_SZ-1:0];
    assign bus.sram_write_data = bus.enq_data;
    assign bus.sram_read_en    = issue;
    assign bus.sram_read_addr  = rd_ptr_q[ADDR_SZ-1:0];

    always_comb begin
        wr_ptr_d   = wr_ptr_q + PW'(enq_fire);
        rd_ptr_d   = rd_ptr_q + PW'(issue);
        inflight_d = issue;
        obuf_d     = obuf_q;
        ob_kept    = ob_cnt_q - {1'b0, deq_fire};
        if (deq_fire)
            obuf_d[0] = obuf_q[1];
        // Returning data lands behind whatever survives this cycle's pop.
        if (inflight_q)
            obuf_d[ob_kept[0]] = bus.sram_read_data;
        ob_cnt_d   = ob_kept + {1'b0, inflight_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            inflight_q <= 1'b0;
            alive_q    <= 1'b0;
            ob_cnt_q   <= 2'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= inflight_d;
            alive_q    <= 1'b1;
            ob_cnt_q   <= ob_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        obuf_q <= obuf_d;
    end
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Bench for sram_fifo_ctrl: queue-level reference model checked every cycle plus directed literals.
module tb_sram_fifo_ctrl;
    localparam int AW = 2;
    localparam int DW = 64;
    localparam int MS = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sram_fifo_if #(.ADDR_SZ(AW), .DATA_SZ(DW)) bus ();
    sram_fifo_ctrl #(.ADDR_SZ(AW), .DATA_SZ(DW), .MEM_SZ(MS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural 1R1W SRAM with registered read.
    logic [DW-1:0] mem [MS];
    always @(posedge clk) begin
        if (bus.sram_write_en) mem[bus.sram_write_addr] <= bus.sram_write_data;
        if (bus.sram_read_en)  bus.sram_read_data <= mem[bus.sram_read_addr];
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference model: entries held in the SRAM, the one being read, and the output buffer.
    logic [DW-1:0] m_sram [$];
    logic [DW-1:0] m_ob [$];
    logic [DW-1:0] m_fl_d;
    bit            m_fl;
    bit            m_alive;
    int            m_wcnt, m_rcnt;
    logic [DW-1:0] got [$];
    int            dq_cyc [$];
    int            cyc = 0;
    bit            e_er, e_fire, d_fire, e_iss;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            chk("rst_enq_ready", bus.enq_ready, 0);
            chk("rst_deq_valid", bus.deq_valid, 0);
            chk("rst_write_en", bus.sram_write_en, 0);
            chk("rst_read_en", bus.sram_read_en, 0);
            chk("rst_addrs", {bus.sram_write_addr, bus.sram_read_addr}, 0);
            m_sram.delete(); m_ob.delete();
            m_fl = 0; m_alive = 0; m_wcnt = 0; m_rcnt = 0;
        end else begin
            e_er   = m_alive && (m_sram.size() != MS);
            e_fire = bus.enq_valid && e_er;
            d_fire = bus.deq_ready && (m_ob.size() != 0);
            e_iss  = (m_sram.size() != 0) && (m_ob.size() + int'(m_fl) - int'(d_fire) < 2);
            chk("enq_ready", bus.enq_ready, e_er);
            chk("deq_valid", bus.deq_valid, m_ob.size() != 0);
            if (m_ob.size() != 0) chk("deq_data", bus.deq_data, m_ob[0]);
            chk("write_en", bus.sram_write_en, e_fire);
            if (e_fire) begin
                chk("write_addr", bus.sram_write_addr, m_wcnt % MS);
                chk("write_data", bus.sram_write_data, bus.enq_data);
            end
            chk("read_en", bus.sram_read_en, e_iss);
            if (e_iss) chk("read_addr", bus.sram_read_addr, m_rcnt % MS);
            if (bus.sram_write_en && bus.sram_read_en)
                chk("rdw_distinct", bus.sram_write_addr != bus.sram_read_addr, 1);
            if (d_fire) begin
                got.push_back(m_ob.pop_front());
                dq_cyc.push_back(cyc);
            end
            if (m_fl) m_ob.push_back(m_fl_d);
            m_fl = e_iss;
            if (e_iss) begin
                m_fl_d = m_sram.pop_front();
                m_rcnt++;
            end
            if (e_fire) begin
                m_sram.push_back(bus.enq_data);
                m_wcnt++;
            end
            m_alive = 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_got(input int n, input int budget);
        int c = 0;
        while (got.size() < n && c < budget) begin
            tick();
            c++;
        end
    endtask

    logic [DW-1:0] exp_q [$];
    int acc, n, cycles;
    logic [DW-1:0] vals [3];

    initial begin
        rst_n = 1'b1;
        bus.enq_valid = 0; bus.enq_data = '0; bus.deq_ready = 0;
        #2 rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;

        // 1: reset release and idle
        @(negedge clk); chk("t1_enq_ready_c0", bus.enq_ready, 0);
        @(negedge clk); chk("t1_enq_ready_c1", bus.enq_ready, 1);
        repeat (3) tick();

        // 2: single entry latency
        got.delete();
        bus.deq_ready = 1; bus.enq_valid = 1; bus.enq_data = 64'hA5;
        @(negedge clk);
        chk("t2_we_N", bus.sram_write_en, 1);
        chk("t2_waddr_N", bus.sram_write_addr, 0);
        tick(); bus.enq_valid = 0;
        @(negedge clk);
        chk("t2_re_N1", bus.sram_read_en, 1);
        chk("t2_raddr_N1", bus.sram_read_addr, 0);
        @(negedge clk); chk("t2_dv_N2", bus.deq_valid, 0);
        @(negedge clk);
        chk("t2_dv_N3", bus.deq_valid, 1);
        chk("t2_dd_N3", bus.deq_data, 64'hA5);
        @(negedge clk); chk("t2_dv_N4", bus.deq_valid, 0);
        tick();

        // 3: fill with consumer stalled
        got.delete();
        bus.deq_ready = 0; acc = 0;
        for (int i = 1; i <= 8; i++) begin
            bus.enq_valid = 1; bus.enq_data = i;
            @(negedge clk);
            if (bus.enq_ready) acc++;
            tick();
        end
        chk("t3_accepted", acc, 6);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_full_no_ready", bus.enq_ready, 0);
            chk("t3_full_no_we", bus.sram_write_en, 0);
            tick();
        end
        bus.enq_valid = 0; bus.deq_ready = 1;
        wait_got(6, 40);
        chk("t3_drained", got.size(), 6);
        for (int i = 0; i < 6 && i < got.size(); i++) chk("t3_order", got[i], i + 1);
        @(negedge clk); chk("t3_ready_back", bus.enq_ready, 1);
        tick();

        // 4: back-to-back streaming with pointer wrap
        got.delete(); dq_cyc.delete();
        n = 0; cycles = 0;
        while (n < 100 && cycles < 400) begin
            bus.enq_valid = 1; bus.enq_data = n;
            @(negedge clk);
            if (bus.enq_ready) n++;
            cycles++;
            tick();
        end
        bus.enq_valid = 0;
        chk("t4_enq_cycles", cycles, 100);
        wait_got(100, 50);
        chk("t4_count", got.size(), 100);
        for (int i = 0; i < 100 && i < got.size(); i++) chk("t4_order", got[i], i);
        if (dq_cyc.size() == 100) chk("t4_deq_span", dq_cyc[99] - dq_cyc[0], 99);

        // 5: random stalls on both sides
        got.delete(); exp_q.delete();
        n = 0; cycles = 0;
        while (got.size() < 1000 && cycles < 12000) begin
            bus.enq_valid = (n < 1000) && ($urandom_range(1, 0) == 1);
            bus.enq_data  = {$urandom, $urandom};
            bus.deq_ready = $urandom_range(1, 0);
            @(negedge clk);
            if (bus.enq_valid && bus.enq_ready) begin
                exp_q.push_back(bus.enq_data);
                n++;
            end
            cycles++;
            tick();
        end
        bus.enq_valid = 0; bus.deq_ready = 1;
        chk("t5_count", got.size(), 1000);
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) chk("t5_order", got[i], exp_q[i]);
        repeat (4) tick();

        // 6: reset with entries queued and a read in flight
        got.delete();
        bus.deq_ready = 0;
        vals[0] = 64'h11; vals[1] = 64'h22; vals[2] = 64'h33;
        for (int i = 0; i < 3; i++) begin
            bus.enq_valid = 1; bus.enq_data = vals[i];
            tick();
        end
        rst_n = 1'b0; bus.enq_valid = 0;
        #1;
        chk("t6_rst_enq_ready", bus.enq_ready, 0);
        chk("t6_rst_deq_valid", bus.deq_valid, 0);
        chk("t6_rst_we", bus.sram_write_en, 0);
        chk("t6_rst_re", bus.sram_read_en, 0);
        repeat (2) tick();
        rst_n = 1'b1; bus.deq_ready = 1;
        repeat (6) tick();
        chk("t6_no_stale", got.size(), 0);
        bus.enq_valid = 1; bus.enq_data = 64'h3C;
        tick();
        bus.enq_valid = 0;
        wait_got(1, 20);
        chk("t6_fresh_count", got.size(), 1);
        if (got.size() > 0) chk("t6_fresh_data", got[0], 64'h3C);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
